lsu_mem_master: RTL and testbench

//  Load/store initiator between the core execute stage and the word-addressed data memory.
//  - Accepts one byte/half/word load or store per request and checks alignment and range.
//  - Sub-word stores use read-modify-write, because the memory only writes full words.
//  - Drives the memory's addr/write_data/write/read pins and sign/zero-extends load data.
//  - Returns a single-cycle response to the core.

---
 rtl/lsu_mem_master.sv | 233 +++++++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator between the core execute stage and a
// word-addressed data memory.
//
// It accepts one byte, half or word access per request and checks it for
// alignment, address range and a legal size code. Sub-word stores are done as
// a read-modify-write because the memory only writes whole words. Load data is
// sign- or zero-extended, and every accepted request gets a single-cycle
// response.
//
// Optional feature, selected by the macro LSU_BYTE_STROBE_EN:
//   When LSU_BYTE_STROBE_EN is defined, the block adds the mem_wstrb byte-lane
//   enables. Sub-word stores then skip the read phase and write the store data
//   replicated across all lanes.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   req_valid/ready request handshake (ready only in IDLE)
//   req_we          1 = store, 0 = load
//   req_funct3      RV32I size/sign code (B, H, W, BU, HU)
//   req_addr        byte address
//   req_wdata       right-justified store data
//   resp_valid      one-cycle completion pulse
//   resp_err        with resp_valid: misaligned, out of range or illegal funct3
//   resp_rdata      extended load data, 0 after a store or error
//   mem_addr        word-aligned byte address to memory
//   mem_write_data  full word to write
//   mem_write       memory write enable
//   mem_read        memory read enable
//   mem_read_data   combinational read data from memory
//   mem_wstrb       byte-lane write enables (LSU_BYTE_STROBE_EN only)

module lsu_mem_master #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
`ifdef LSU_BYTE_STROBE_EN
  output logic [3:0]  mem_wstrb,
`endif
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  localparam logic [31:0] BYTE_LIMIT = 32'(4 * MEM_WORDS);

  state_t      state;
  logic [1:0]  lat_addr_lo;
  logic [2:0]  lat_funct3;
  logic        req_err;
  logic [31:0] load_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
`ifndef LSU_BYTE_STROBE_EN
  logic [15:0] lat_wdata;
  logic [31:0] merged_word;
`endif

  // The request is classified before it is accepted. Stores only allow
  // B/H/W. Sizes H and HU need an even address. W needs a word-aligned
  // address.
  always_comb begin
    req_err = 1'b0;
    if (req_we) begin
      if (!(req_funct3 inside {3'b000, 3'b001, 3'b010})) req_err = 1'b1;
    end else begin
      if (!(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) req_err = 1'b1;
    end
    if (req_funct3[1:0] == 2'b01 && req_addr[0]) req_err = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if (req_addr >= BYTE_LIMIT) req_err = 1'b1;
  end

  // The byte lane and half lane are picked from the read word. funct3[2]
  // selects zero-extension; otherwise the value is sign-extended.
  always_comb begin
    ld_byte = mem_read_data[7:0];
    case (lat_addr_lo)
      2'd1: ld_byte = mem_read_data[15:8];
      2'd2: ld_byte = mem_read_data[23:16];
      2'd3: ld_byte = mem_read_data[31:24];
      default: ld_byte = mem_read_data[7:0];
    endcase
    ld_half = lat_addr_lo[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (lat_funct3)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_data = {24'h0, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_data = {16'h0, ld_half};
      default: load_data = mem_read_data;
    endcase
  end

`ifndef LSU_BYTE_STROBE_EN
  // Read-modify-write merge: SH replaces the addressed half, SB replaces
  // the addressed byte, and the rest of the word is kept as read.
  always_comb begin
    merged_word = mem_read_data;
    if (lat_funct3[0]) begin
      if (lat_addr_lo[1]) merged_word[31:16] = lat_wdata;
      else                merged_word[15:0]  = lat_wdata;
    end else begin
      case (lat_addr_lo)
        2'd0: merged_word[7:0]   = lat_wdata[7:0];
        2'd1: merged_word[15:8]  = lat_wdata[7:0];
        2'd2: merged_word[23:16] = lat_wdata[7:0];
        default: merged_word[31:24] = lat_wdata[7:0];
      endcase
    end
  end
`endif

  // Main controller. All memory-side and response outputs are registered
  // here. resp_valid is set on the same edge that enters RESP, so it is high
  // exactly while the FSM is in RESP. An asynchronous reset clears mem_write
  // at once, so an access that is in flight never completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      resp_rdata     <= 32'h0;
      mem_addr       <= 32'h0;
      mem_write_data <= 32'h0;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
      lat_addr_lo    <= 2'b00;
      lat_funct3     <= 3'b000;
`ifdef LSU_BYTE_STROBE_EN
      mem_wstrb      <= 4'h0;
`else
      lat_wdata      <= 16'h0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready   <= 1'b0;
            lat_addr_lo <= req_addr[1:0];
            lat_funct3  <= req_funct3;
            mem_addr    <= {req_addr[31:2], 2'b00};
`ifndef LSU_BYTE_STROBE_EN
            lat_wdata   <= req_wdata[15:0];
`endif
            if (req_err) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
              state      <= RESP;
            end else if (!req_we) begin
              mem_read <= 1'b1;
              state    <= LOAD;
            end else if (req_funct3 == 3'b010) begin
              mem_write      <= 1'b1;
              mem_write_data <= req_wdata;
`ifdef LSU_BYTE_STROBE_EN
              mem_wstrb      <= 4'b1111;
`endif
              state          <= WRITE;
            end else begin
`ifdef LSU_BYTE_STROBE_EN
              // Strobed sub-word store: the data is replicated so the
              // addressed lane carries it whatever the offset.
              mem_write <= 1'b1;
              if (req_funct3[0]) begin
                mem_write_data <= {2{req_wdata[15:0]}};
                mem_wstrb      <= req_addr[1] ? 4'b1100 : 4'b0011;
              end else begin
                mem_write_data <= {4{req_wdata[7:0]}};
                mem_wstrb      <= 4'b0001 << req_addr[1:0];
              end
              state <= WRITE;
`else
              mem_read <= 1'b1;
              state    <= RMW_RD;
`endif
            end
          end
        end
        LOAD: begin
          mem_read   <= 1'b0;
          resp_rdata <= load_data;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RMW_RD: begin
`ifdef LSU_BYTE_STROBE_EN
          mem_read  <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
`else
          mem_read       <= 1'b0;
          mem_write      <= 1'b1;
          mem_write_data <= merged_word;
          state          <= WRITE;
`endif
        end
        WRITE: begin
          mem_write  <= 1'b0;
          resp_rdata <= 32'h0;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: scoreboard bench for lsu_mem_master.
//
// A byte-array reference model predicts the error flag, the load value, the
// latency and the memory word after each store. The driver pushes that
// prediction when a request is accepted. The monitor pops and compares it
// when resp_valid appears. The simulated memory is an ordinary word array;
// the block can only change it through its mem_* pins.

module tb_lsu_mem_master;

  localparam int MEM_WORDS = 256;
  localparam int MEM_BYTES = 4 * MEM_WORDS;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;
`ifdef LSU_BYTE_STROBE_EN
  logic [3:0]  mem_wstrb;
`endif

  lsu_mem_master #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read),
`ifdef LSU_BYTE_STROBE_EN
    .mem_wstrb(mem_wstrb),
`endif
    .mem_read_data(mem_read_data)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
    logic        is_store;
    int          addr;
    int          size;
    logic [31:0] wdata;
  } item_t;

  item_t       sb_q[$];
  logic [31:0] mem [MEM_WORDS];
  logic [7:0]  ref_bytes [MEM_BYTES];
  int          cycle;
  int          n_checks;
  int          n_fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Simulated memory with combinational read and write on the clock edge.
  assign mem_read_data = (mem_addr < 32'(MEM_BYTES)) ? mem[mem_addr[9:2]] : 32'h0;

  always @(posedge clk) begin
    if (!rst && mem_write && mem_addr < 32'(MEM_BYTES)) begin
`ifdef LSU_BYTE_STROBE_EN
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
`else
      mem[mem_addr[9:2]] <= mem_write_data;
`endif
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] refWord(input int idx);
    return {ref_bytes[4*idx+3], ref_bytes[4*idx+2], ref_bytes[4*idx+1], ref_bytes[4*idx]};
  endfunction

  // Reference model: derive the response from the RV32I access rules.
  function automatic item_t predict(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                    input logic [31:0] wdata);
    item_t it;
    int size;
    logic legal;
    size = 1 << f3[1:0];
    if (we) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    it.err = !legal || (addr >= 32'(MEM_BYTES)) || (legal && (addr % size) != 0);
    it.is_store = we;
    it.addr = int'(addr);
    it.size = size;
    it.wdata = wdata;
    it.acc = 0;
    it.rdata = 32'h0;
    if (it.err) it.lat = 1;
`ifdef LSU_BYTE_STROBE_EN
    else if (we) it.lat = 2;
`else
    else if (we) it.lat = (size == 4) ? 2 : 3;
`endif
    else begin
      it.lat = 2;
      for (int i = 0; i < size; i++) it.rdata |= 32'(ref_bytes[addr + i]) << (8 * i);
      if (!f3[2] && size == 1 && it.rdata[7])  it.rdata |= 32'hFFFFFF00;
      if (!f3[2] && size == 2 && it.rdata[15]) it.rdata |= 32'hFFFF0000;
    end
    return it;
  endfunction

  // Drive one request; optionally keep req_valid high afterwards so that the
  // next call forms a back-to-back stream.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit hold);
    int waited;
    item_t it;
    @(negedge clk);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("accept_timeout", {31'h0, req_ready}, 32'h1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    it = predict(we, f3, addr, wdata);
    @(posedge clk);
    #1;
    it.acc = cycle;
    sb_q.push_back(it);
    if (!hold) req_valid = 1'b0;
  endtask

  // Monitor: checks the handshake and memory pins every cycle and the
  // response when it appears.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("req_ready", {31'h0, req_ready}, {31'h0, sb_q.size() == 0});
      if (sb_q.size() == 0) checkOutput("spurious_resp", {31'h0, resp_valid}, 32'h0);
      if (mem_read || mem_write) begin
        checkOutput("mem_rw_both", {31'h0, mem_read && mem_write}, 32'h0);
        checkOutput("mem_on_err", {31'h0, (sb_q.size() > 0) ? sb_q[0].err : 1'b1}, 32'h0);
      end
      if (resp_valid && sb_q.size() > 0) begin
        item_t it;
        it = sb_q.pop_front();
        checkOutput("resp_err", {31'h0, resp_err}, {31'h0, it.err});
        checkOutput("resp_rdata", resp_rdata, it.rdata);
        checkOutput("latency", 32'(cycle - it.acc + 1), 32'(it.lat));
        if (it.is_store && !it.err) begin
          for (int i = 0; i < it.size; i++) ref_bytes[it.addr + i] = it.wdata[8*i +: 8];
          checkOutput("mem_word", mem[it.addr / 4], refWord(it.addr / 4));
        end
      end else if (sb_q.size() > 0 && cycle - sb_q[0].acc > 8) begin
        checkOutput("resp_timeout", {31'h0, resp_valid}, 32'h1);
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    int n;
    logic [31:0] a;
    logic [2:0]  f;
    cycle = 0;
    n_checks = 0;
    n_fails = 0;
    for (int w = 0; w < MEM_WORDS; w++) begin
      mem[w] = $urandom;
      for (int b = 0; b < 4; b++) ref_bytes[4*w + b] = mem[w][8*b +: 8];
    end
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'b000;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    checkOutput("rst_mem_write", {31'h0, mem_write}, 32'h0);
    checkOutput("rst_mem_read", {31'h0, mem_read}, 32'h0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    rst = 1'b0;

    $display("[TB] directed word/byte/half accesses");
    applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    applyStimulus(1'b1, 3'b000, 32'h11, 32'h00000055, 1'b0);
    applyStimulus(1'b0, 3'b000, 32'h11, 32'h0, 1'b0);
    applyStimulus(1'b0, 3'b000, 32'h13, 32'h0, 1'b0);
    applyStimulus(1'b0, 3'b100, 32'h13, 32'h0, 1'b0);
    applyStimulus(1'b1, 3'b001, 32'h12, 32'h00001234, 1'b0);
    applyStimulus(1'b0, 3'b001, 32'h12, 32'h0, 1'b0);
    applyStimulus(1'b0, 3'b101, 32'h12, 32'h0, 1'b0);

    $display("[TB] error cases");
    applyStimulus(1'b0, 3'b010, 32'h02, 32'h0, 1'b0);
    applyStimulus(1'b1, 3'b001, 32'h01, 32'hFFFF, 1'b0);
    applyStimulus(1'b0, 3'b010, 32'h400, 32'h0, 1'b0);
    applyStimulus(1'b0, 3'b011, 32'h20, 32'h0, 1'b0);
    applyStimulus(1'b1, 3'b100, 32'h20, 32'h0, 1'b0);
    applyStimulus(1'b0, 3'b000, 32'h3FF, 32'h0, 1'b0);

    $display("[TB] reset during a store");
    applyStimulus(1'b1, 3'b000, 32'h10, 32'h000000AA, 1'b0);
    n = 0;
    while (!mem_write && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("rst_reach_write", {31'h0, mem_write}, 32'h1);
    #1;
    rst = 1'b1;
    sb_q.delete();
    #1;
    checkOutput("rst_mid_mem_write", {31'h0, mem_write}, 32'h0);
    checkOutput("rst_mid_req_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("rst_mid_resp_valid", {31'h0, resp_valid}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);

    $display("[TB] back-to-back requests");
    applyStimulus(1'b1, 3'b010, 32'h40, 32'h80818283, 1'b1);
    applyStimulus(1'b1, 3'b000, 32'h43, 32'h000000F1, 1'b1);
    applyStimulus(1'b0, 3'b000, 32'h43, 32'h0, 1'b1);
    applyStimulus(1'b0, 3'b010, 32'h41, 32'h0, 1'b1);
    applyStimulus(1'b1, 3'b001, 32'h40, 32'h0000ABCD, 1'b1);
    applyStimulus(1'b0, 3'b010, 32'h40, 32'h0, 1'b0);

    $display("[TB] random traffic");
    for (int k = 0; k < 300; k++) begin
      f = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) a = 32'(MEM_BYTES) + 32'($urandom_range(0, 7));
      else a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) != 0) begin
        if (f[1:0] == 2'b01) a[0] = 1'b0;
        if (f[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      applyStimulus(1'($urandom_range(0, 1)), f, a, $urandom, 1'($urandom_range(0, 3) == 0));
    end

    req_valid = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("drain", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
